// File: rtl/play_time_formatter.sv
// BCD frame builder for the 8-digit display: mm:ss elapsed play time, volume and track number.
// Define WRAP_99_EN to make the time roll over from 99:59 to 00:00 instead of saturating.
module play_time_formatter #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause_tgl,
    input  logic       stop,
    input  logic [7:0] track_num,
    input  logic [3:0] volume,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic [3:0] hex3,
    output logic [3:0] hex4,
    output logic [3:0] hex5,
    output logic [3:0] hex6,
    output logic [3:0] hex7,
    output logic [7:0] dp_out,
    output logic [7:0] idigit,
    output logic       is_playing
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [3:0]    sec_ones_q, sec_ones_d;
    logic [3:0]    sec_tens_q, sec_tens_d;
    logic [3:0]    min_ones_q, min_ones_d;
    logic [3:0]    min_tens_q, min_tens_d;
    logic          dp_sep_q, dp_sep_d;
    logic          is_playing_q, is_playing_d;
    logic [3:0]    trk_tens_q, trk_tens_d;
    logic [3:0]    trk_ones_q, trk_ones_d;
    logic [3:0]    vol_tens_q, vol_tens_d;
    logic [3:0]    vol_ones_q, vol_ones_d;
    logic          sec_tick;
    logic          at_max;
    logic [7:0]    trk_sat;

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = PLAY;
        end else if (pause_tgl) begin
            if (state_q == PLAY) begin
                state_d = PAUSE;
            end else if (state_q == PAUSE) begin
                state_d = PLAY;
            end
        end
        is_playing_d = (state_d == PLAY);
    end

    // The prescaler only moves while playing, so a pause keeps the partial second.
    always_comb begin
        pre_d      = pre_q;
        sec_tick   = 1'b0;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        at_max     = (min_tens_q == 4'd9) && (min_ones_q == 4'd9) &&
                     (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);

        if (stop || start) begin
            pre_d      = '0;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else if (state_q == PLAY) begin
            if (pre_q == PRE_MAX) begin
                pre_d    = '0;
                sec_tick = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        if (sec_tick) begin
            if (at_max) begin
`ifdef WRAP_99_EN
                sec_ones_d = 4'd0;
                sec_tens_d = 4'd0;
                min_ones_d = 4'd0;
                min_tens_d = 4'd0;
`else
                sec_ones_d = sec_ones_q;
`endif
            end else if (sec_ones_q != 4'd9) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q != 4'd5) begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_ones_q != 4'd9) begin
                        min_ones_d = min_ones_q + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        min_tens_d = min_tens_q + 4'd1;
                    end
                end
            end
        end
    end

    // Separator is lit on entry to PAUSE and then flips every BLINK_DIV cycles.
    always_comb begin
        blink_d  = '0;
        dp_sep_d = 1'b0;
        case (state_d)
            PLAY: dp_sep_d = 1'b1;
            PAUSE: begin
                if (state_q == PAUSE) begin
                    if (blink_q == BLINK_MAX) begin
                        blink_d  = '0;
                        dp_sep_d = ~dp_sep_q;
                    end else begin
                        blink_d  = blink_q + BW'(1);
                        dp_sep_d = dp_sep_q;
                    end
                end else begin
                    dp_sep_d = 1'b1;
                end
            end
            default: dp_sep_d = 1'b0;
        endcase
    end

    always_comb begin
        trk_sat    = (track_num > 8'd99) ? 8'd99 : track_num;
        trk_tens_d = 4'd0;
        trk_ones_d = trk_sat[3:0];
        for (int k = 1; k <= 9; k++) begin
            if (trk_sat >= 8'(10 * k)) begin
                trk_tens_d = 4'(k);
                trk_ones_d = 4'(trk_sat - 8'(10 * k));
            end
        end
        if (volume >= 4'd10) begin
            vol_tens_d = 4'd1;
            vol_ones_d = volume - 4'd10;
        end else begin
            vol_tens_d = 4'd0;
            vol_ones_d = volume;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pre_q        <= '0;
            blink_q      <= '0;
            sec_ones_q   <= 4'd0;
            sec_tens_q   <= 4'd0;
            min_ones_q   <= 4'd0;
            min_tens_q   <= 4'd0;
            dp_sep_q     <= 1'b0;
            is_playing_q <= 1'b0;
            trk_tens_q   <= 4'd0;
            trk_ones_q   <= 4'd0;
            vol_tens_q   <= 4'd0;
            vol_ones_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            blink_q      <= blink_d;
            sec_ones_q   <= sec_ones_d;
            sec_tens_q   <= sec_tens_d;
            min_ones_q   <= min_ones_d;
            min_tens_q   <= min_tens_d;
            dp_sep_q     <= dp_sep_d;
            is_playing_q <= is_playing_d;
            trk_tens_q   <= trk_tens_d;
            trk_ones_q   <= trk_ones_d;
            vol_tens_q   <= vol_tens_d;
            vol_ones_q   <= vol_ones_d;
        end
    end

    assign hex0       = sec_ones_q;
    assign hex1       = sec_tens_q;
    assign hex2       = min_ones_q;
    assign hex3       = min_tens_q;
    assign hex4       = vol_ones_q;
    assign hex5       = vol_tens_q;
    assign hex6       = trk_ones_q;
    assign hex7       = trk_tens_q;
    assign dp_out     = {5'b00000, dp_sep_q, 2'b00};
    assign idigit     = 8'hFF;
    assign is_playing = is_playing_q;

endmodule

// File: tb/tb_play_time_formatter.sv
// Directed self-checking bench for play_time_formatter with TICK_DIV=10, BLINK_DIV=4.
// Expected values are hand-computed; WRAP_99_EN selects the rollover expectation.
module tb_play_time_formatter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause_tgl;
    logic       stop;
    logic [7:0] track_num;
    logic [3:0] volume;
    logic [3:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [7:0] dp_out;
    logic [7:0] idigit;
    logic       is_playing;

    int checkCount;
    int failCount;

    play_time_formatter #(
        .TICK_DIV (10),
        .BLINK_DIV(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause_tgl (pause_tgl),
        .stop      (stop),
        .track_num (track_num),
        .volume    (volume),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .hex4      (hex4),
        .hex5      (hex5),
        .hex6      (hex6),
        .hex7      (hex7),
        .dp_out    (dp_out),
        .idigit    (idigit),
        .is_playing(is_playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic st);
        start     = s;
        pause_tgl = p;
        stop      = st;
        tick(1);
        start     = 1'b0;
        pause_tgl = 1'b0;
        stop      = 1'b0;
    endtask

    function automatic logic [15:0] timeVal();
        return {hex3, hex2, hex1, hex0};
    endfunction

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        pause_tgl  = 1'b0;
        stop       = 1'b0;
        track_num  = 8'd0;
        volume     = 4'd0;

        // 1: reset values
        tick(3);
        checkOutput("rst_time", 32'(timeVal()), 32'h0000);
        checkOutput("rst_trkvol", 32'({hex7, hex6, hex5, hex4}), 32'h0000);
        checkOutput("rst_dp", 32'(dp_out), 32'h00);
        checkOutput("rst_idigit", 32'(idigit), 32'hFF);
        checkOutput("rst_playing", 32'(is_playing), 32'h0);
        rst_n = 1'b1;
        tick(5);
        checkOutput("idle_time", 32'(timeVal()), 32'h0000);
        checkOutput("idle_dp", 32'(dp_out), 32'h00);

        // 2: count through a minute boundary
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start_playing", 32'(is_playing), 32'h1);
        checkOutput("start_dp", 32'(dp_out), 32'h04);
        tick(9);
        checkOutput("pre_first_tick", 32'(timeVal()), 32'h0000);
        tick(1);
        checkOutput("first_tick", 32'(timeVal()), 32'h0001);
        tick(580);
        checkOutput("t_00_59", 32'(timeVal()), 32'h0059);
        checkOutput("t_00_59_dp", 32'(dp_out), 32'h04);
        tick(10);
        checkOutput("t_01_00", 32'(timeVal()), 32'h0100);
        checkOutput("t_01_00_dp", 32'(dp_out), 32'h04);

        // 3: pause 3 cycles into second 6, blink, resume
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(52);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pause_time", 32'(timeVal()), 32'h0005);
        checkOutput("pause_playing", 32'(is_playing), 32'h0);
        checkOutput("blink_0", 32'(dp_out), 32'h04);
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            checkOutput($sformatf("blink_%0d", i), 32'(dp_out), ((i / 4) % 2 == 0) ? 32'h04 : 32'h00);
            checkOutput($sformatf("pause_hold_%0d", i), 32'(timeVal()), 32'h0005);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("resume_playing", 32'(is_playing), 32'h1);
        checkOutput("resume_dp", 32'(dp_out), 32'h04);
        tick(6);
        checkOutput("resume_6", 32'(timeVal()), 32'h0005);
        tick(1);
        checkOutput("resume_7", 32'(timeVal()), 32'h0006);

        // 4: track and volume conversion
        track_num = 8'd123;
        volume    = 4'd15;
        tick(1);
        checkOutput("trk123_vol15", 32'({hex7, hex6, hex5, hex4}), 32'h9915);
        track_num = 8'd7;
        volume    = 4'd0;
        tick(1);
        checkOutput("trk7_vol0", 32'({hex7, hex6, hex5, hex4}), 32'h0700);
        track_num = 8'd99;
        volume    = 4'd10;
        tick(1);
        checkOutput("trk99_vol10", 32'({hex7, hex6, hex5, hex4}), 32'h9910);
        track_num = 8'd100;
        volume    = 4'd9;
        tick(1);
        checkOutput("trk100_vol9", 32'({hex7, hex6, hex5, hex4}), 32'h9909);
        track_num = 8'd58;
        volume    = 4'd3;
        tick(1);
        checkOutput("trk58_vol3", 32'({hex7, hex6, hex5, hex4}), 32'h5803);

        // 5: stop beats start; pause ignored in IDLE
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(300);
        checkOutput("t_00_30", 32'(timeVal()), 32'h0030);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("stopstart_time", 32'(timeVal()), 32'h0000);
        checkOutput("stopstart_dp", 32'(dp_out), 32'h00);
        checkOutput("stopstart_playing", 32'(is_playing), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("idle_pause_playing", 32'(is_playing), 32'h0);
        checkOutput("idle_pause_dp", 32'(dp_out), 32'h00);
        tick(20);
        checkOutput("idle_no_count", 32'(timeVal()), 32'h0000);

        // 6: long run to 99:59 and beyond
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(5990);
        checkOutput("t_09_59", 32'(timeVal()), 32'h0959);
        tick(10);
        checkOutput("t_10_00", 32'(timeVal()), 32'h1000);
        tick(53990);
        checkOutput("t_99_59", 32'(timeVal()), 32'h9959);
        tick(10);
`ifdef WRAP_99_EN
        checkOutput("t_after_99_59", 32'(timeVal()), 32'h0000);
        tick(10);
        checkOutput("t_after_wrap", 32'(timeVal()), 32'h0001);
`else
        checkOutput("t_after_99_59", 32'(timeVal()), 32'h9959);
        tick(10);
        checkOutput("t_saturated", 32'(timeVal()), 32'h9959);
`endif

        // async reset mid-play, checked before any further clock edge
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(25);
        checkOutput("pre_reset_time", 32'(timeVal()), 32'h0002);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_time", 32'(timeVal()), 32'h0000);
        checkOutput("async_rst_trkvol", 32'({hex7, hex6, hex5, hex4}), 32'h0000);
        checkOutput("async_rst_dp", 32'(dp_out), 32'h00);
        checkOutput("async_rst_idigit", 32'(idigit), 32'hFF);
        checkOutput("async_rst_playing", 32'(is_playing), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
